// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the five-stage MIPS core.
// Owns the fetch PC and drives a synchronous instruction SRAM with one-cycle
// read latency. It feeds ID over the IF->ID bus and takes ID's branch bus,
// which carries redirects resolved in ID. The MIPS delay slot is honoured.
// Optional feature macro: IF_INST_BUFFER_EN adds a one-entry instruction
// holding register. It keeps the instruction stable across stalls even when
// the SRAM output changes while the read enable is low.

package id_stage_params;
  typedef struct packed {
    logic        branch_taken;
    logic [31:0] branch_target;
  } IDToIFBranchBusData;
endpackage

package if_stage_params;
  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [31:0] instruction;
  } IFToIDInstructionBusData;
endpackage

// Handshake: IF presents valid with {program_count, instruction}. The word
// moves into ID on a posedge where valid && id_allow_in. While valid is high
// and id_allow_in is low, every bus field holds stable and no new fetch is
// issued.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     id_allow_in,
  input  id_stage_params::IDToIFBranchBusData      id_to_if_branch_bus,
  output if_stage_params::IFToIDInstructionBusData if_to_id_instruction_bus,
  output logic                                     inst_sram_en,
  output logic [3:0]                               inst_sram_wen,
  output logic [31:0]                              inst_sram_addr,
  output logic [31:0]                              inst_sram_wdata,
  input  logic [31:0]                              inst_sram_rdata
);

  logic        pre_if_valid;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_ready_go;
  logic        if_allow_in;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic [31:0] instruction;

  // Fetch always completes in one cycle. IF may accept a new word when it is
  // empty or when its current word moves into ID this cycle.
  assign if_ready_go = 1'b1;
  assign if_allow_in = !if_valid || (if_ready_go && id_allow_in);

  // The redirect is taken only when ID accepts the delay slot in the same
  // edge. A stalled ID keeps re-asserting the branch bus, so IF does not
  // store a pending redirect.
  assign seq_pc  = if_pc + 32'd4;
  assign next_pc = (id_to_if_branch_bus.branch_taken && id_allow_in)
                   ? id_to_if_branch_bus.branch_target : seq_pc;

  assign inst_sram_en    = pre_if_valid && if_allow_in;
  assign inst_sram_addr  = next_pc;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;

  // pre-IF turns on one cycle after reset is released and then stays on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pre_if_valid <= 1'b0;
    else       pre_if_valid <= 1'b1;
  end

  // IF register. The PC advances only on an edge where a fetch was actually
  // issued, so the first fetched address is RESET_VECTOR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_pc    <= RESET_VECTOR - 32'd4;
    end else if (if_allow_in) begin
      if_valid <= pre_if_valid;
      if (pre_if_valid) if_pc <= next_pc;
    end
  end

`ifdef IF_INST_BUFFER_EN
  logic        buf_valid;
  logic [31:0] inst_buf;

  // Capture the SRAM word on the first stalled cycle. Release it on any
  // advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      inst_buf  <= 32'b0;
    end else if (if_allow_in) begin
      buf_valid <= 1'b0;
    end else if (if_valid && !id_allow_in && !buf_valid) begin
      buf_valid <= 1'b1;
      inst_buf  <= inst_sram_rdata;
    end
  end

  assign instruction = buf_valid ? inst_buf : inst_sram_rdata;
`else
  // Without the buffer, stalls rely on the SRAM holding its output while
  // the enable is low.
  assign instruction = inst_sram_rdata;
`endif

  assign if_to_id_instruction_bus.valid         = if_valid;
  assign if_to_id_instruction_bus.program_count = if_pc;
  assign if_to_id_instruction_bus.instruction   = instruction;

endmodule
